fba_accumulator: RTL and testbench
==================================

FBA_ACCUMULATOR -- requirements
Module: fba_accumulator

Interface
REQ-001 The block SHALL have parameter N_TERMS, default 9, meaning terms per frame (legal range 1..255).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 The block SHALL have port in_valid, input, 1, meaning in_data carries a term.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts a term this cycle.
REQ-006 The block SHALL have port in_data, input, 16, the unsigned term to accumulate.
REQ-007 The block SHALL have port in_last, input, 1, meaning the accepted term ends the frame early.
REQ-008 The block SHALL have port out_valid, output, 1, meaning a frame result is presented.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-010 The block SHALL have port out_sum, output, 16, the approximate frame sum.
REQ-011 The block SHALL have port out_ovf, output, 1, the sticky overflow flag for the frame.
REQ-012 The block SHALL have port out_cnt, output, 8, the number of terms accepted in the frame.

Function
REQ-013 The block SHALL combine operands with the fixed-bounding rule fba(A,B), defined by REQ-014 to REQ-016.
REQ-014 Upper byte: {c, Y[15:8]} = A[15:8] + B[15:8], exact 9-bit result; no carry enters from the low byte.
REQ-015 Low byte: k = highest index in 7..0 with A[k]&B[k]=1; Y[k:0] = all ones and Y[7:k+1] = A[7:k+1] | B[7:k+1].
REQ-016 Low byte when no such k exists: Y[7:0] = A[7:0] | B[7:0].
REQ-017 A term transfers when in_valid & in_ready are both high at a rising clk edge.
REQ-018 The block SHALL use two states: ACC (in_ready=1, out_valid=0) and DONE (in_ready=0, out_valid=1).
REQ-019 In ACC, on each transfer: acc <= fba(acc, in_data); cnt <= cnt+1.
REQ-020 Overflow: if c=1, or if ovf is already set, then acc <= 16'hFFFF and ovf <= 1; ovf stays set until the frame is consumed.
REQ-021 ACC->DONE on the transfer that makes cnt = N_TERMS, or on any transfer with in_last=1, whichever occurs first.
REQ-022 out_sum, out_ovf and out_cnt SHALL be registered, valid in the cycle after the final transfer (latency 1), and held stable while out_valid=1 and out_ready=0.
REQ-023 DONE->ACC on out_valid & out_ready; in the same edge acc <= 0, ovf <= 0, cnt <= 0.
REQ-024 The block SHALL impose exactly one bubble per frame: it accepts no term in the cycle in which the result handshake occurs.
REQ-025 Cycles in ACC with in_valid=0 SHALL leave acc, ovf and cnt unchanged.
REQ-026 The block SHALL ignore in_last when no transfer occurs.
REQ-027 N_TERMS=1: every transfer ends a frame, and out_sum = fba(0, in_data) = in_data.

Reset
REQ-028 While rst_n=0: state=ACC, acc=0, ovf=0, cnt=0, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0, and in_ready forced to 0.
REQ-029 rst_n falling mid-frame or in DONE SHALL discard the partial or pending result with no output handshake; the first transfer after release starts a new frame at cnt=0.
REQ-030 in_ready SHALL go high in the first cycle after rst_n deasserts.

Verification
REQ-031 Basic add: terms 16'h0103 then 16'h0101 with in_last=1 -> out_sum=16'h0203, out_ovf=0, out_cnt=2.
REQ-032 Bounding: with N_TERMS=9, nine terms of 16'h0001 -> out_sum=16'h0001, out_cnt=9, and out_valid high exactly 1 cycle after the 9th transfer.
REQ-033 Overflow: 16'hF000 then 16'h2000 then 16'h0001 with in_last -> out_sum=16'hFFFF, out_ovf=1, out_cnt=3.
REQ-034 Backpressure: out_ready held low 5 cycles in DONE -> out_valid=1, outputs stable, in_ready=0 throughout; the next frame's first result starts from acc=0.
REQ-035 Reset mid-frame: 4 terms of 16'h0100, then rst_n low 2 cycles, then 1 term 16'h0005 with in_last -> out_sum=16'h0005, out_cnt=1, with no output handshake before it.
REQ-036 Gaps: random in_valid idle cycles inside a frame -> results identical to the gap-free run, checked against a reference model built from REQ-014 to REQ-016.

Source files
------------

// File: rtl/fba_accumulator.sv
// Frame accumulator built on the fixed-bounding adder fba(A,B).
// The upper byte is added exactly and its carry flags overflow. The low byte
// is approximated: every bit at or below the highest position where both
// operands are 1 is forced to 1, and the bits above it are ORed.
// Terms stream in through a valid/ready input. A frame ends when N_TERMS
// terms have been accepted, or earlier on a term with in_last. The result
// is then held at the output until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid/in_ready     term handshake
//   in_data[15:0]         unsigned term
//   in_last               accepted term ends the frame early
//   out_valid/out_ready   result handshake
//   out_sum[15:0]         approximate frame sum (16'hFFFF after overflow)
//   out_ovf               sticky overflow flag for the frame
//   out_cnt[7:0]          number of terms accepted in the frame
module fba_accumulator #(
    parameter int unsigned N_TERMS = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_ovf,
    output logic [7:0]  out_cnt
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 8;
    localparam int unsigned BW = 8;

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    // Fixed-bounding add; returns {carry, sum}.
    function automatic logic [DW:0] fba(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [BW:0]   hi;
        logic [BW-1:0] both;
        logic [BW-1:0] lo;
        logic          hit;
        hi   = {1'b0, a[DW-1:BW]} + {1'b0, b[DW-1:BW]};
        both = a[BW-1:0] & b[BW-1:0];
        lo   = '0;
        hit  = 1'b0;
        // Once the highest common 1 is reached, every lower bit is forced high.
        for (int i = BW - 1; i >= 0; i--) begin
            hit   = hit | both[i];
            lo[i] = hit | a[i] | b[i];
        end
        return {hi, lo};
    endfunction

    state_t          state, state_n;
    logic [DW-1:0]   acc, acc_n;
    logic            ovf, ovf_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW-1:0]   sum_n;
    logic            out_ovf_n;
    logic [CW-1:0]   out_cnt_n;
    logic            in_ready_n;
    logic            out_valid_n;
    logic [DW:0]     fba_r;
    logic            take;

    // State, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
            out_cnt   <= '0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            ovf       <= ovf_n;
            cnt       <= cnt_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_sum   <= sum_n;
            out_ovf   <= out_ovf_n;
            out_cnt   <= out_cnt_n;
        end
    end

    // Next-state, datapath update and next output values.
    always_comb begin
        state_n   = state;
        acc_n     = acc;
        ovf_n     = ovf;
        cnt_n     = cnt;
        sum_n     = out_sum;
        out_ovf_n = out_ovf;
        out_cnt_n = out_cnt;
        fba_r     = fba(acc, in_data);
        // in_ready is low for one cycle after reset even though state is ACC.
        take      = in_valid & in_ready;

        unique case (state)
            ACC: begin
                if (take) begin
                    cnt_n = cnt + CW'(1);
                    if (fba_r[DW] || ovf) begin
                        acc_n = {DW{1'b1}};
                        ovf_n = 1'b1;
                    end else begin
                        acc_n = fba_r[DW-1:0];
                    end
                    if (in_last || (cnt_n == CW'(N_TERMS))) begin
                        state_n   = DONE;
                        sum_n     = acc_n;
                        out_ovf_n = ovf_n;
                        out_cnt_n = cnt_n;
                    end
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_n = ACC;
                    acc_n   = '0;
                    ovf_n   = 1'b0;
                    cnt_n   = '0;
                end
            end
            default: state_n = ACC;
        endcase

        in_ready_n  = (state_n == ACC);
        out_valid_n = (state_n == DONE);
    end

endmodule

// File: tb/tb_fba_accumulator.sv
// Directed bench for fba_accumulator (N_TERMS = 9): reset values, basic add,
// count bounding, overflow, backpressure, mid-frame reset and idle gaps.
module tb_fba_accumulator;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic [7:0]  out_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    fba_accumulator #(.N_TERMS(9)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_sum  (out_sum),
        .out_ovf  (out_ovf),
        .out_cnt  (out_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: exact high byte, low byte = (a|b) with a mask up to the top common 1.
    function automatic logic [16:0] ref_fba(input logic [15:0] a, input logic [15:0] b);
        logic [8:0] hi;
        logic [7:0] lo;
        int k;
        hi = 9'(a[15:8]) + 9'(b[15:8]);
        lo = a[7:0] | b[7:0];
        k  = -1;
        for (int i = 0; i < 8; i++) if (a[i] & b[i]) k = i;
        if (k >= 0) lo = lo | 8'((32'd1 << (k + 1)) - 1);
        return {hi, lo};
    endfunction

    // Called at a negedge; returns at the negedge after the transfer edge.
    task automatic send(input logic [15:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
        if (!in_ready) check("send_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called at a negedge; waits for out_valid, checks, completes the handshake.
    task automatic take_result(input string tag, input logic [15:0] s, input logic o, input logic [7:0] c);
        out_ready = 1'b1;
        for (int t = 0; t < 50 && !out_valid; t++) @(negedge clk);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_sum"},   32'(out_sum),   32'(s));
        check({tag, "_ovf"},   32'(out_ovf),   32'(o));
        check({tag, "_cnt"},   32'(out_cnt),   32'(c));
        check({tag, "_bubble"}, 32'(in_ready), 32'd0);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] acc_m;
        logic        ovf_m;
        logic [16:0] r;
        int          len;
        logic [15:0] term;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_out_cnt",   32'(out_cnt),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 32'(in_ready), 32'd1);

        // Basic add: 0103 + 0101 -> 0203
        send(16'h0103, 1'b0);
        send(16'h0101, 1'b1);
        check("basic_latency", 32'(out_valid), 32'd1);
        take_result("basic", 16'h0203, 1'b0, 8'd2);

        // Bounding by count: nine 0001 terms -> 0001
        for (int i = 0; i < 8; i++) send(16'h0001, 1'b0);
        check("bound_pre_valid", 32'(out_valid), 32'd0);
        send(16'h0001, 1'b0);
        check("bound_latency", 32'(out_valid), 32'd1);
        take_result("bound", 16'h0001, 1'b0, 8'd9);

        // Overflow: F000 + 2000 carries out of the high byte, then stays sticky
        send(16'hF000, 1'b0);
        send(16'h2000, 1'b0);
        send(16'h0001, 1'b1);
        take_result("ovf", 16'hFFFF, 1'b1, 8'd3);

        // Backpressure: 1234 then 0021 -> 123F, held 5 cycles
        send(16'h1234, 1'b0);
        send(16'h0021, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready),  32'd0);
            check("bp_sum",   32'(out_sum),   32'h123F);
            check("bp_cnt",   32'(out_cnt),   32'd2);
            @(negedge clk);
        end
        take_result("bp", 16'h123F, 1'b0, 8'd2);
        send(16'h0005, 1'b1);
        take_result("bp_next", 16'h0005, 1'b0, 8'd1);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 4; i++) send(16'h0100, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(in_ready),  32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rel_valid", 32'(out_valid), 32'd0);
        send(16'h0005, 1'b1);
        take_result("mid_rst", 16'h0005, 1'b0, 8'd1);

        // Reset while a result is pending
        send(16'h0042, 1'b1);
        rst_n = 1'b0;
        #1;
        check("done_rst_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(16'h0300, 1'b1);
        take_result("done_rst", 16'h0300, 1'b0, 8'd1);

        // Random frames with idle gaps; in_last toggles while idle and must be ignored
        for (int f = 0; f < 6; f++) begin
            len   = int'($urandom_range(1, 9));
            acc_m = '0;
            ovf_m = 1'b0;
            for (int i = 0; i < len; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
                    in_last = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                term = 16'($urandom);
                if (f < 2) term = term & 16'h3FFF;
                r = ref_fba(acc_m, term);
                if (r[16] || ovf_m) begin
                    acc_m = 16'hFFFF;
                    ovf_m = 1'b1;
                end else begin
                    acc_m = r[15:0];
                end
                send(term, (i == len - 1) && (len < 9));
            end
            take_result("gap", acc_m, ovf_m, 8'(len));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
